// File: rtl/circle_motion_ctrl.sv
// Per-frame centre update for the circle renderer: moves the centre by STEP on each axis
// during vertical blank, bouncing off the edges of the active area.
module circle_motion_ctrl #(
    parameter int HACTIVE = 800,
    parameter int VACTIVE = 600,
    parameter int R       = 50,
    parameter int STEP    = 4,
    parameter int INIT_X  = 400,
    parameter int INIT_Y  = 300
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               frame_start,
    input  logic               pause,
    input  logic               set_pos,
    input  logic signed [10:0] set_x,
    input  logic signed [10:0] set_y,
    output logic signed [10:0] centerX,
    output logic signed [10:0] centerY,
    output logic               dir_x,
    output logic               dir_y,
    output logic               update_done,
    output logic [7:0]         bounce_cnt
);

    localparam logic signed [11:0] XMIN   = 12'(R);
    localparam logic signed [11:0] XMAX   = 12'(HACTIVE - 1 - R);
    localparam logic signed [11:0] YMIN   = 12'(R);
    localparam logic signed [11:0] YMAX   = 12'(VACTIVE - 1 - R);
    localparam logic signed [11:0] STEP12 = 12'(STEP);

    typedef enum logic [1:0] {IDLE, MOVE_X, MOVE_Y, DONE} state_t;

    state_t             state_q, state_d;
    logic signed [10:0] cx_q, cx_d, cy_q, cy_d;
    logic               dx_q, dx_d, dy_q, dy_d;
    logic               done_q, done_d;
    logic [7:0]         bc_q, bc_d;
    logic signed [11:0] nx, ny;

    // Widened to 12 bits so out-of-range loads compare correctly against the limits.
    function automatic logic signed [10:0] clampAxis(input logic signed [10:0] v,
                                                     input logic signed [11:0] lo,
                                                     input logic signed [11:0] hi);
        logic signed [11:0] w;
        w = $signed({v[10], v});
        if (w < lo)      return $signed(lo[10:0]);
        else if (w > hi) return $signed(hi[10:0]);
        else             return v;
    endfunction

    assign nx = dx_q ? ($signed({cx_q[10], cx_q}) + STEP12) : ($signed({cx_q[10], cx_q}) - STEP12);
    assign ny = dy_q ? ($signed({cy_q[10], cy_q}) + STEP12) : ($signed({cy_q[10], cy_q}) - STEP12);

    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        bc_d    = bc_q;
        done_d  = 1'b0;
        if (set_pos) begin
            cx_d    = clampAxis(set_x, XMIN, XMAX);
            cy_d    = clampAxis(set_y, YMIN, YMAX);
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (frame_start && !pause) state_d = MOVE_X;
                end
                MOVE_X: begin
                    if (nx > XMAX) begin
                        cx_d = $signed(XMAX[10:0]);
                        dx_d = 1'b0;
                        bc_d = bc_q + 8'd1;
                    end else if (nx < XMIN) begin
                        cx_d = $signed(XMIN[10:0]);
                        dx_d = 1'b1;
                        bc_d = bc_q + 8'd1;
                    end else begin
                        cx_d = $signed(nx[10:0]);
                    end
                    state_d = MOVE_Y;
                end
                MOVE_Y: begin
                    if (ny > YMAX) begin
                        cy_d = $signed(YMAX[10:0]);
                        dy_d = 1'b0;
                        bc_d = bc_q + 8'd1;
                    end else if (ny < YMIN) begin
                        cy_d = $signed(YMIN[10:0]);
                        dy_d = 1'b1;
                        bc_d = bc_q + 8'd1;
                    end else begin
                        cy_d = $signed(ny[10:0]);
                    end
                    // Registered so the pulse lines up with the DONE cycle.
                    done_d  = 1'b1;
                    state_d = DONE;
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cx_q    <= 11'(INIT_X);
            cy_q    <= 11'(INIT_Y);
            dx_q    <= 1'b1;
            dy_q    <= 1'b1;
            done_q  <= 1'b0;
            bc_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            done_q  <= done_d;
            bc_q    <= bc_d;
        end
    end

    assign centerX     = cx_q;
    assign centerY     = cy_q;
    assign dir_x       = dx_q;
    assign dir_y       = dy_q;
    assign update_done = done_q;
    assign bounce_cnt  = bc_q;

endmodule

// File: tb/tb_circle_motion_ctrl.sv
// Table-driven bench for circle_motion_ctrl with a scoreboard of expected centre states
// plus hand-written sequences for latency, dropped frames and mid-update reset.
module tb_circle_motion_ctrl;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               frame_start = 1'b0;
    logic               pause = 1'b0;
    logic               set_pos = 1'b0;
    logic signed [10:0] set_x = '0;
    logic signed [10:0] set_y = '0;
    logic signed [10:0] centerX, centerY;
    logic               dir_x, dir_y, update_done;
    logic [7:0]         bounce_cnt;

    int total = 0;
    int bad = 0;

    localparam int K_SET   = 0;
    localparam int K_FRAME = 1;
    localparam int K_PAUSE = 2;

    typedef struct packed {
        logic signed [10:0] cx;
        logic signed [10:0] cy;
        logic               dx;
        logic               dy;
        logic [7:0]         bc;
    } exp_t;

    typedef struct {
        int                 kind;
        logic signed [10:0] sx;
        logic signed [10:0] sy;
        exp_t               e;
        string              name;
    } vec_t;

    vec_t vecs[$];
    exp_t sb[$];

    circle_motion_ctrl dut (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .pause(pause),
        .set_pos(set_pos), .set_x(set_x), .set_y(set_y),
        .centerX(centerX), .centerY(centerY), .dir_x(dir_x), .dir_y(dir_y),
        .update_done(update_done), .bounce_cnt(bounce_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input exp_t e);
        total++;
        if (centerX !== e.cx || centerY !== e.cy || dir_x !== e.dx || dir_y !== e.dy || bounce_cnt !== e.bc) begin
            bad++;
            $display("[TB] FAIL %s: got x=%0d y=%0d dx=%0b dy=%0b bc=%0d, want x=%0d y=%0d dx=%0b dy=%0b bc=%0d",
                     name, centerX, centerY, dir_x, dir_y, bounce_cnt, e.cx, e.cy, e.dx, e.dy, e.bc);
        end
    endtask

    task automatic checkCount(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    // Waits (bounded) at negedges for update_done.
    task automatic waitDone(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (update_done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic countPulses(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            if (update_done) n++;
            @(negedge clk);
        end
    endtask

    task automatic pulseFrame();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        bit   seen;
        int   n;
        exp_t e;
        case (v.kind)
            K_SET: begin
                @(negedge clk);
                set_pos = 1'b1;
                set_x   = v.sx;
                set_y   = v.sy;
                sb.push_back(v.e);
                @(negedge clk);
                set_pos = 1'b0;
                e = sb.pop_front();
                checkOutput(v.name, e);
            end
            K_FRAME: begin
                sb.push_back(v.e);
                pulseFrame();
                waitDone(seen);
                e = sb.pop_front();
                if (!seen) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL %s: update_done got 0 within 8 cycles, want 1", v.name);
                end else begin
                    checkOutput(v.name, e);
                    @(negedge clk);
                    checkCount({v.name, "_donewidth"}, int'(update_done), 0);
                end
            end
            default: begin
                pause = 1'b1;
                sb.push_back(v.e);
                pulseFrame();
                countPulses(6, n);
                pause = 1'b0;
                checkCount({v.name, "_nodone"}, n, 0);
                e = sb.pop_front();
                checkOutput(v.name, e);
            end
        endcase
    endtask

    initial begin
        bit seen;
        int n;

        vecs.push_back('{K_SET,   11'sd748, 11'sd300, '{11'sd748, 11'sd300, 1'b1, 1'b1, 8'd0}, "set748"});
        vecs.push_back('{K_FRAME, 11'sd0,   11'sd0,   '{11'sd749, 11'sd304, 1'b0, 1'b1, 8'd1}, "bounceXmax"});
        vecs.push_back('{K_FRAME, 11'sd0,   11'sd0,   '{11'sd745, 11'sd308, 1'b0, 1'b1, 8'd1}, "afterXmax"});
        vecs.push_back('{K_SET,   11'sd745, 11'sd548, '{11'sd745, 11'sd548, 1'b0, 1'b1, 8'd1}, "set548"});
        vecs.push_back('{K_FRAME, 11'sd0,   11'sd0,   '{11'sd741, 11'sd549, 1'b0, 1'b0, 8'd2}, "bounceYmax"});
        vecs.push_back('{K_SET,   11'sd52,  11'sd52,  '{11'sd52,  11'sd52,  1'b0, 1'b0, 8'd2}, "set52"});
        vecs.push_back('{K_FRAME, 11'sd0,   11'sd0,   '{11'sd50,  11'sd50,  1'b1, 1'b1, 8'd4}, "bounceBoth"});
        vecs.push_back('{K_SET,  -11'sd5,   11'sd1000,'{11'sd50,  11'sd549, 1'b1, 1'b1, 8'd4}, "setClamp"});
        vecs.push_back('{K_FRAME, 11'sd0,   11'sd0,   '{11'sd54,  11'sd549, 1'b1, 1'b0, 8'd5}, "clampYmax"});
        vecs.push_back('{K_SET,   11'sd745, 11'sd300, '{11'sd745, 11'sd300, 1'b1, 1'b0, 8'd5}, "set745"});
        vecs.push_back('{K_FRAME, 11'sd0,   11'sd0,   '{11'sd749, 11'sd296, 1'b1, 1'b0, 8'd5}, "landOnLimit"});
        vecs.push_back('{K_FRAME, 11'sd0,   11'sd0,   '{11'sd749, 11'sd292, 1'b0, 1'b0, 8'd6}, "holdAtLimit"});
        vecs.push_back('{K_FRAME, 11'sd0,   11'sd0,   '{11'sd745, 11'sd288, 1'b0, 1'b0, 8'd6}, "leaveLimit"});
        for (int i = 0; i < 3; i++)
            vecs.push_back('{K_PAUSE, 11'sd0, 11'sd0, '{11'sd745, 11'sd288, 1'b0, 1'b0, 8'd6}, "paused"});

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("reset", '{11'sd400, 11'sd300, 1'b1, 1'b1, 8'd0});
        checkCount("resetDone", int'(update_done), 0);

        // Latency: frame_start sampled at edge P0; X updates at P1, Y and update_done at P2.
        pulseFrame();
        @(negedge clk);
        checkOutput("latX", '{11'sd404, 11'sd300, 1'b1, 1'b1, 8'd0});
        checkCount("latDoneEarly", int'(update_done), 0);
        @(negedge clk);
        checkOutput("latY", '{11'sd404, 11'sd304, 1'b1, 1'b1, 8'd0});
        checkCount("latDone", int'(update_done), 1);
        @(negedge clk);
        checkCount("latDoneWidth", int'(update_done), 0);

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // set_pos with frame_start in the same cycle drops the frame.
        @(negedge clk);
        set_pos = 1'b1; set_x = 11'sd400; set_y = 11'sd300; frame_start = 1'b1;
        @(negedge clk);
        set_pos = 1'b0; frame_start = 1'b0;
        countPulses(8, n);
        checkCount("setDropsFrame", n, 0);
        checkOutput("setWithFrame", '{11'sd400, 11'sd300, 1'b0, 1'b0, 8'd6});

        // frame_start during MOVE_Y is ignored, not queued.
        pulseFrame();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        countPulses(10, n);
        checkCount("ignoreInMoveY", n, 1);
        checkOutput("afterIgnore", '{11'sd396, 11'sd296, 1'b0, 1'b0, 8'd6});

        // Reset during MOVE_X returns outputs immediately with no pulse.
        pulseFrame();
        reset_n = 1'b0;
        #1;
        checkOutput("midReset", '{11'sd400, 11'sd300, 1'b1, 1'b1, 8'd0});
        countPulses(4, n);
        checkCount("midResetNoDone", n, 0);
        reset_n = 1'b1;
        pulseFrame();
        waitDone(seen);
        checkCount("postResetDone", int'(seen), 1);
        checkOutput("postResetFrame", '{11'sd404, 11'sd304, 1'b1, 1'b1, 8'd0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/circle_motion_ctrl.md
Name: circle_motion_ctrl

Overview:
- Sequences the circle renderer by updating its centre once per video frame. The circle bounces off the edges of the active area.
- Sits between the video timing generator (frame_start pulse) and the circle renderer's centerX/centerY inputs.
- The centre changes only in the few cycles after frame_start (vertical blank), so the circle is never torn mid-frame.

Parameters:
- HACTIVE, 800, active pixels per line.
- VACTIVE, 600, active lines.
- R, 50, circle radius; the centre is kept in [R, HACTIVE-1-R] x [R, VACTIVE-1-R].
- STEP, 4, pixels moved per axis per frame; 1..R.
- INIT_X, 400, centre X at reset.
- INIT_Y, 300, centre Y at reset.

Ports:
- clk  in  1  pixel clock.
- reset_n  in  1  asynchronous reset, active low.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- pause  in  1  when high, frame updates are skipped.
- set_pos  in  1  one-cycle load strobe.
- set_x  in  11 signed  X to load on set_pos.
- set_y  in  11 signed  Y to load on set_pos.
- centerX  out  11 signed  circle centre X, registered.
- centerY  out  11 signed  circle centre Y, registered.
- dir_x  out  1  1 = moving +X, 0 = moving -X.
- dir_y  out  1  1 = moving +Y, 0 = moving -Y.
- update_done  out  1  one-cycle pulse when a frame update completes.
- bounce_cnt  out  8  count of edge bounces; wraps 255 -> 0.

Behaviour:
- Reset (reset_n low, asynchronous):
  - centerX=INIT_X, centerY=INIT_Y.
  - dir_x=1, dir_y=1.
  - update_done=0, bounce_cnt=0.
  - state=IDLE.
- Limits: XMIN=R, XMAX=HACTIVE-1-R (749), YMIN=R, YMAX=VACTIVE-1-R (549).
- FSM states: IDLE, MOVE_X, MOVE_Y, DONE.
  - IDLE: frame_start=1 and pause=0 -> MOVE_X. Otherwise stay.
  - MOVE_X: nx = centerX + STEP if dir_x, else centerX - STEP.
    - If nx > XMAX: centerX<=XMAX, dir_x<=0, bounce_cnt++.
    - If nx < XMIN: centerX<=XMIN, dir_x<=1, bounce_cnt++.
    - Otherwise centerX<=nx.
    - Next state MOVE_Y.
  - MOVE_Y: same rule on the Y axis with YMIN/YMAX and dir_y. Next state DONE.
  - DONE: update_done=1 for this cycle only (registered). Next state IDLE.
- Latency: frame_start sampled in cycle 0.
  - centerX has its new value from cycle 2.
  - centerY has its new value from cycle 3.
  - update_done is high in cycle 3.
- Arithmetic: evaluate nx/ny at 12-bit signed width so no overflow is possible.
- Landing exactly on a limit does not flip direction. The flip happens on the following frame, which clamps to the same limit, so the centre holds for one frame.
- Both axes bouncing in the same frame increments bounce_cnt by 2: +1 in MOVE_X, +1 in MOVE_Y.
- frame_start outside IDLE is ignored. It is not queued.
- pause is sampled only in IDLE. Raising pause mid-update does not abort the update.
- set_pos has priority over everything, in any state:
  - centerX <= set_x clamped to [XMIN, XMAX]; centerY <= set_y clamped to [YMIN, YMAX].
  - Directions and bounce_cnt are unchanged.
  - state <= IDLE; update_done=0 next cycle.
  - A frame_start in the same cycle as set_pos is dropped.
- Reset asserted mid-update: all outputs return to reset values immediately. No update_done pulse.

Test Plan:
- Reset release, one frame_start -> cycle 2: centerX=404; cycle 3: centerY=304, update_done=1 for exactly 1 cycle; bounce_cnt=0.
- set_pos (748,300), then frame_start -> centerX=749, dir_x=0, bounce_cnt=1. Next frame -> centerX=745, dir_x=0.
- set_pos (52,52) with dir_x=0, dir_y=0 after a bounce sequence, then frame_start -> centre (50,50), dir_x=1, dir_y=1, bounce_cnt increments by 2.
- set_pos (-5,1000) -> centre (50,549) next cycle. set_pos with frame_start in the same cycle -> no update_done.
- pause=1 during 3 frame_starts -> centre unchanged, no update_done. frame_start in MOVE_Y cycle -> ignored, exactly one update_done.
- reset_n low during MOVE_X -> centre (400,300) asynchronously, update_done=0, bounce_cnt=0. The next frame moves to (404,304).
